// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio -- memory-mapped 8N1 UART transmitter on the data bus.
//
// Snoops the data-memory bus and decodes an 8-byte window at BASE_ADDR.
// Bytes written to TXDATA are queued in a small FIFO and shifted out
// LSB-first on tx, with back-to-back frames sent without idle gaps.
//
// Ports:
//   clk        system clock (same clock as the data memory)
//   reset      asynchronous active-high reset
//   addr       data bus address
//   write_data data bus write data
//   memwrite   bus write strobe, sampled on rising clk
//   memread    bus read strobe
//   read_data  register read data, 0 when not selected or not reading
//   sel        address falls inside this block's window
//   tx         serial output, idle high
//
// Register map (addr[2] selects, addr[1:0] ignored):
//   0x0 TXDATA  write pushes write_data[7:0]; reads as 0
//   0x4 STATUS  read : [0] full [1] empty [2] busy [3] overflow [7:4] count
//               write: bit3=1 clears overflow
module uart_tx_mmio #(
   parameter int          CLKS_PER_BIT = 104,
   parameter int          FIFO_DEPTH   = 8,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_2000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   input  logic        memwrite,
   input  logic        memread,
   output logic [31:0] read_data,
   output logic        sel,
   output logic        tx
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t              state, state_nx;
   logic [BAUD_W-1:0]   baud_cnt, baud_nx;
   logic [2:0]          bit_idx, bit_nx;
   logic [7:0]          shift, shift_nx;
   logic                tx_nx;

   logic [7:0]          fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    count;
   logic                overflow;

   logic                full, empty, busy, baud_last;
   logic                push_req, push, pop, clr_ovf;
   logic [31:0]         count_w;
   logic [3:0]          cnt4;
   logic                unused_bits;

   assign unused_bits = ^{addr[1:0], write_data[31:8]};

   assign sel       = (addr[31:3] == BASE_ADDR[31:3]);
   assign full      = (count == CNT_W'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign busy      = (state != IDLE);
   assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

   // Fullness is judged on the pre-edge count; a same-cycle pop does not
   // make room for the incoming byte.
   assign push_req  = sel & memwrite & ~addr[2];
   assign push      = push_req & ~full;
   assign clr_ovf   = sel & memwrite & addr[2] & write_data[3];

   // The STATUS count field is only 4 bits wide, so deep FIFOs saturate.
   assign count_w   = 32'(count);
   assign cnt4      = (count_w > 32'd15) ? 4'hF : count_w[3:0];

   always_comb begin
      read_data = '0;
      if (!reset && sel && memread && addr[2])
         read_data = {24'b0, cnt4, overflow, busy, empty, full};
   end

   // FIFO storage: data only, never reset.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= write_data[7:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
         // A dropped push wins over a simultaneous clear.
         if (push_req && full)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_nx;
         baud_cnt <= baud_nx;
         bit_idx  <= bit_nx;
         tx       <= tx_nx;
      end
   end

   always_ff @(posedge clk) begin
      shift <= shift_nx;
   end

   always_comb begin
      state_nx = state;
      baud_nx  = baud_cnt;
      bit_nx   = bit_idx;
      shift_nx = shift;
      pop      = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               shift_nx = fifo_mem[rd_ptr];
               baud_nx  = '0;
               bit_nx   = '0;
               state_nx = START;
            end
         end
         START: begin
            if (baud_last) begin
               baud_nx  = '0;
               state_nx = DATA;
            end else
               baud_nx = baud_cnt + BAUD_W'(1);
         end
         DATA: begin
            if (baud_last) begin
               baud_nx  = '0;
               shift_nx = {1'b0, shift[7:1]};
               if (bit_idx == 3'd7)
                  state_nx = STOP;
               else
                  bit_nx = bit_idx + 3'd1;
            end else
               baud_nx = baud_cnt + BAUD_W'(1);
         end
         STOP: begin
            if (baud_last) begin
               baud_nx = '0;
               // Chain straight into the next start bit when data waits.
               if (!empty) begin
                  pop      = 1'b1;
                  shift_nx = fifo_mem[rd_ptr];
                  bit_nx   = '0;
                  state_nx = START;
               end else
                  state_nx = IDLE;
            end else
               baud_nx = baud_cnt + BAUD_W'(1);
         end
         default: state_nx = IDLE;
      endcase

      // tx is registered from the next state so the pin never glitches.
      case (state_nx)
         START:   tx_nx = 1'b0;
         DATA:    tx_nx = shift_nx[0];
         default: tx_nx = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed testbench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_uart_tx_mmio;

   localparam int          CPB  = 4;
   localparam logic [31:0] BASE = 32'h0000_2000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic        memwrite;
   logic        memread;
   logic [31:0] read_data;
   logic        sel;
   logic        tx;

   int vectors = 0;
   int miscompares = 0;

   uart_tx_mmio #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (8),
      .BASE_ADDR    (BASE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .addr       (addr),
      .write_data (write_data),
      .memwrite   (memwrite),
      .memread    (memread),
      .read_data  (read_data),
      .sel        (sel),
      .tx         (tx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called just after a falling edge; the write lands on the next rising edge.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr       = a;
      write_data = d;
      memwrite   = 1'b1;
      memread    = 1'b0;
      @(negedge clk);
      memwrite   = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      addr    = a;
      memread = 1'b1;
      #1;
      v       = read_data;
   endtask

   // Checks frame samples start..39 of byte b, one per falling edge.
   task automatic check_frame(input logic [7:0] b, input int start, input string tag);
      logic [9:0] bits;
      bits     = {1'b1, b, 1'b0};
      addr     = BASE + 32'h4;
      memread  = 1'b1;
      memwrite = 1'b0;
      for (int i = start; i < 10 * CPB; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("%s tx[%0d]", tag, i), {31'b0, tx}, {31'b0, bits[i / CPB]});
         chk($sformatf("%s busy[%0d]", tag, i), {31'b0, read_data[2]}, 32'd1);
      end
   endtask

   logic [31:0] v;

   initial begin
      reset      = 1'b1;
      addr       = '0;
      write_data = '0;
      memwrite   = 1'b0;
      memread    = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      rd(BASE + 32'h4, v);
      chk("reset tx", {31'b0, tx}, 32'd1);
      chk("reset read_data", v, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      rd(BASE + 32'h4, v);
      chk("post-reset status", v, 32'h02);
      chk("post-reset sel", {31'b0, sel}, 32'd1);

      // Single byte 0x55
      wr(BASE, 32'h55);
      rd(BASE + 32'h4, v);
      chk("queued status", v, 32'h10);
      chk("tx before start", {31'b0, tx}, 32'd1);
      check_frame(8'h55, 0, "b55");
      @(negedge clk);
      rd(BASE + 32'h4, v);
      chk("idle after 55", v, 32'h02);
      chk("tx idle after 55", {31'b0, tx}, 32'd1);

      // Back-to-back frames
      wr(BASE, 32'hA3);
      wr(BASE, 32'h0F);
      #1;
      chk("bb start", {31'b0, tx}, 32'd0);
      check_frame(8'hA3, 1, "bA3");
      check_frame(8'h0F, 0, "b0F");
      @(negedge clk);
      rd(BASE + 32'h4, v);
      chk("idle after bb", v, 32'h02);

      // Overflow: 10 consecutive writes, the last is dropped
      for (int i = 0; i < 10; i++)
         wr(BASE, 32'h10 + i);
      rd(BASE + 32'h4, v);
      chk("overflow status", v, 32'h8D);
      wr(BASE + 32'h4, 32'h08);
      rd(BASE + 32'h4, v);
      chk("ovf cleared", v, 32'h85);
      wr(BASE, 32'h77);
      rd(BASE + 32'h4, v);
      chk("ovf set again", v, 32'h8D);
      wr(BASE + 32'h4, 32'hF7);
      rd(BASE + 32'h4, v);
      chk("ovf not cleared by bit3=0", v, 32'h8D);
      wr(BASE + 32'h4, 32'h08);
      rd(BASE + 32'h4, v);
      chk("ovf cleared again", v, 32'h85);
      check_frame(8'h10, 13, "b10");
      for (int i = 1; i < 9; i++)
         check_frame(8'h10 + 8'(i), 0, $sformatf("b%0h", 8'h10 + 8'(i)));
      for (int i = 0; i < 3 * CPB; i++) begin
         @(negedge clk);
         #1;
         chk("idle after drain", {31'b0, tx}, 32'd1);
      end
      rd(BASE + 32'h4, v);
      chk("status after drain", v, 32'h02);

      // Reset during DATA bit 3
      wr(BASE, 32'hC6);
      wr(BASE, 32'h81);
      repeat (17) @(negedge clk);
      #1;
      chk("C6 bit3 before reset", {31'b0, tx}, 32'd0);
      reset = 1'b1;
      #1;
      chk("async reset tx", {31'b0, tx}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      rd(BASE + 32'h4, v);
      chk("status after mid reset", v, 32'h02);
      for (int i = 0; i < 12 * CPB; i++) begin
         @(negedge clk);
         #1;
         chk("no residual frame", {31'b0, tx}, 32'd1);
      end

      // Address decode
      addr       = BASE + 32'h8;
      write_data = 32'h41;
      memwrite   = 1'b1;
      #1;
      chk("sel BASE+8", {31'b0, sel}, 32'd0);
      @(negedge clk);
      addr = 32'h0;
      #1;
      chk("sel 0x0", {31'b0, sel}, 32'd0);
      @(negedge clk);
      memwrite = 1'b0;
      rd(BASE + 32'h4, v);
      chk("count unchanged", v, 32'h02);
      rd(BASE + 32'h8, v);
      chk("read BASE+8", v, 32'h0);
      rd(BASE - 32'h4, v);
      chk("read BASE-4", v, 32'h0);
      chk("sel BASE-4", {31'b0, sel}, 32'd0);
      rd(BASE + 32'h0, v);
      chk("read TXDATA", v, 32'h0);
      rd(BASE + 32'h5, v);
      chk("read STATUS alias", v, 32'h02);
      memread = 1'b0;
      addr    = BASE + 32'h4;
      #1;
      chk("read memread=0", read_data, 32'h0);
      repeat (2) @(negedge clk);
      #1;
      chk("tx idle after decode", {31'b0, tx}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
